// File: rtl/order_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : order_dispatcher
// Description : Turns strategy buy/sell edges into 5-byte order messages on a
//               valid/ready byte stream, with position limit and cooldown.
// Revision    : 1.0 - initial release
// ============================================================================
module order_dispatcher #(
    parameter logic [7:0]  QTY      = 8'd1,
    parameter logic [7:0]  MAX_POS  = 8'd16,
    parameter logic [15:0] COOLDOWN = 16'd16,
    parameter logic [7:0]  BUY_OP   = 8'h42,
    parameter logic [7:0]  SELL_OP  = 8'h53
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buy_order,
    input  logic       sell_order,
    input  logic [7:0] price,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] position,
    output logic       busy,
    output logic       reject,
    output logic [7:0] drop_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        COOL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        side_q, side_d;          // 1 = sell
    logic [7:0]  price_q, price_d;
    logic [7:0]  mseq_q, mseq_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  pos_q, pos_d;
    logic [7:0]  drop_q, drop_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        reject_q, reject_d;
    logic        prev_buy_q, prev_buy_d;
    logic        prev_sell_q, prev_sell_d;

    logic              w_buy_req, w_sell_req, w_single, w_limit_ok;
    logic              w_accept, w_drop, w_handshake;
    logic signed [9:0] w_pos_ext, w_qty_ext, w_max_ext;
    logic [7:0]        w_op, w_checksum, w_next_byte;
    logic [2:0]        w_next_idx;

    assign w_buy_req  = buy_order & ~prev_buy_q;
    assign w_sell_req = sell_order & ~prev_sell_q;
    assign w_single   = w_buy_req ^ w_sell_req;

    // Widened to 10 bits so the limit check cannot wrap at the 8-bit boundary
    assign w_pos_ext  = {{2{pos_q[7]}}, pos_q};
    assign w_qty_ext  = {2'b00, QTY};
    assign w_max_ext  = {2'b00, MAX_POS};
    assign w_limit_ok = w_buy_req ? ((w_pos_ext + w_qty_ext) <= w_max_ext)
                                  : ((w_pos_ext - w_qty_ext) >= -w_max_ext);

    assign w_accept    = (state_q == IDLE) & w_single & w_limit_ok;
    assign w_drop      = (w_buy_req & w_sell_req)
                       | ((w_buy_req | w_sell_req) & (state_q != IDLE))
                       | ((state_q == IDLE) & w_single & ~w_limit_ok);
    assign w_handshake = valid_q & tx_ready;

    assign w_op       = side_q ? SELL_OP : BUY_OP;
    assign w_checksum = w_op ^ mseq_q ^ price_q ^ QTY;
    assign w_next_idx = idx_q + 3'd1;

    always_comb begin
        w_next_byte = 8'h00;
        case (w_next_idx)
            3'd1:    w_next_byte = mseq_q;
            3'd2:    w_next_byte = price_q;
            3'd3:    w_next_byte = QTY;
            3'd4:    w_next_byte = w_checksum;
            default: w_next_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        side_d      = side_q;
        price_d     = price_q;
        mseq_d      = mseq_q;
        seq_d       = seq_q;
        pos_d       = pos_q;
        data_d      = data_q;
        valid_d     = valid_q;
        prev_buy_d  = buy_order;
        prev_sell_d = sell_order;
        reject_d    = w_drop;
        drop_d      = (w_drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = SEND;
                    side_d  = w_sell_req;
                    price_d = price;
                    mseq_d  = seq_q;
                    idx_d   = 3'd0;
                    valid_d = 1'b1;
                    data_d  = w_sell_req ? SELL_OP : BUY_OP;
                end
            end
            SEND: begin
                if (w_handshake) begin
                    if (idx_q == 3'd4) begin
                        valid_d = 1'b0;
                        data_d  = 8'h00;
                        pos_d   = side_q ? pos_q - QTY : pos_q + QTY;
                        seq_d   = seq_q + 8'd1;
                        if (COOLDOWN == 16'd0) begin
                            state_d = IDLE;
                        end else begin
                            state_d = COOL;
                            cnt_d   = COOLDOWN;
                        end
                    end else begin
                        idx_d  = w_next_idx;
                        data_d = w_next_byte;
                    end
                end
            end
            COOL: begin
                if (cnt_q <= 16'd1) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            cnt_q       <= 16'd0;
            side_q      <= 1'b0;
            price_q     <= 8'h00;
            mseq_q      <= 8'h00;
            seq_q       <= 8'h00;
            pos_q       <= 8'h00;
            drop_q      <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            reject_q    <= 1'b0;
            prev_buy_q  <= 1'b0;
            prev_sell_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            side_q      <= side_d;
            price_q     <= price_d;
            mseq_q      <= mseq_d;
            seq_q       <= seq_d;
            pos_q       <= pos_d;
            drop_q      <= drop_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            reject_q    <= reject_d;
            prev_buy_q  <= prev_buy_d;
            prev_sell_q <= prev_sell_d;
        end
    end

    assign tx_data    = data_q;
    assign tx_valid   = valid_q;
    assign position   = pos_q;
    assign busy       = (state_q != IDLE);
    assign reject     = reject_q;
    assign drop_count = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_order_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_order_dispatcher
// Description : Drives two dispatcher configurations with the same stimulus and
//               compares every output each cycle against a message-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_order_dispatcher;

    localparam int NDUT = 2;
    localparam int QTY  = 1;

    logic       clk = 1'b0;
    logic       reset, buy_order, sell_order, tx_ready;
    logic [7:0] price;

    logic [7:0] tx_data0, position0, drop_count0;
    logic       tx_valid0, busy0, reject0;
    logic [7:0] tx_data1, position1, drop_count1;
    logic       tx_valid1, busy1, reject1;

    int checks = 0;
    int errors = 0;

    // Model: bytes still to send, cooldown cycles left, position, sequence
    int         m_left  [NDUT];
    int         m_cool  [NDUT];
    int         m_pos   [NDUT];
    int         m_seq   [NDUT];
    int         m_drops [NDUT];
    int         m_delta [NDUT];
    bit         m_rej   [NDUT];
    bit         m_pb    [NDUT];
    bit         m_ps    [NDUT];
    logic [7:0] m_msg   [NDUT][5];

    always #5 clk = ~clk;

    order_dispatcher dut0 (
        .clk(clk), .reset(reset), .buy_order(buy_order), .sell_order(sell_order),
        .price(price), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .position(position0), .busy(busy0), .reject(reject0), .drop_count(drop_count0)
    );

    order_dispatcher #(.MAX_POS(8'd2), .COOLDOWN(16'd0)) dut1 (
        .clk(clk), .reset(reset), .buy_order(buy_order), .sell_order(sell_order),
        .price(price), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .position(position1), .busy(busy1), .reject(reject1), .drop_count(drop_count1)
    );

    function automatic int p_max(input int d);
        return (d == 0) ? 16 : 2;
    endfunction

    function automatic int p_cool(input int d);
        return (d == 0) ? 16 : 0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int d);
        bit breq, sreq, busy_pre;
        int np;
        logic [7:0] op;
        if (reset) begin
            m_left[d] = 0; m_cool[d] = 0; m_pos[d] = 0; m_seq[d] = 0;
            m_drops[d] = 0; m_rej[d] = 0; m_pb[d] = 0; m_ps[d] = 0;
            return;
        end
        breq = buy_order && !m_pb[d];
        sreq = sell_order && !m_ps[d];
        m_pb[d] = buy_order;
        m_ps[d] = sell_order;
        busy_pre = (m_left[d] > 0) || (m_cool[d] > 0);
        m_rej[d] = 0;
        if (m_left[d] > 0) begin
            if (tx_ready) begin
                m_left[d]--;
                if (m_left[d] == 0) begin
                    m_pos[d]  = m_pos[d] + m_delta[d] * QTY;
                    m_seq[d]  = (m_seq[d] + 1) % 256;
                    m_cool[d] = p_cool(d);
                end
            end
        end else if (m_cool[d] > 0) begin
            m_cool[d]--;
        end
        if (breq || sreq) begin
            if ((breq && sreq) || busy_pre) begin
                m_rej[d] = 1;
            end else begin
                np = m_pos[d] + (breq ? QTY : -QTY);
                if (np > p_max(d) || np < -p_max(d)) begin
                    m_rej[d] = 1;
                end else begin
                    op = breq ? 8'h42 : 8'h53;
                    m_delta[d]  = breq ? 1 : -1;
                    m_msg[d][0] = op;
                    m_msg[d][1] = 8'(m_seq[d]);
                    m_msg[d][2] = price;
                    m_msg[d][3] = 8'(QTY);
                    m_msg[d][4] = op ^ 8'(m_seq[d]) ^ price ^ 8'(QTY);
                    m_left[d]   = 5;
                end
            end
        end
        if (m_rej[d]) m_drops[d]++;
    endtask

    task automatic check_dut(input int d);
        logic [7:0] o_d, o_p, o_c;
        logic       o_v, o_b, o_r, e_v, e_b;
        o_d = (d == 0) ? tx_data0    : tx_data1;
        o_p = (d == 0) ? position0   : position1;
        o_c = (d == 0) ? drop_count0 : drop_count1;
        o_v = (d == 0) ? tx_valid0   : tx_valid1;
        o_b = (d == 0) ? busy0       : busy1;
        o_r = (d == 0) ? reject0     : reject1;
        e_v = (m_left[d] > 0);
        e_b = (m_left[d] > 0) || (m_cool[d] > 0);
        chk($sformatf("dut%0d tx_valid", d), {7'b0, o_v}, {7'b0, e_v});
        if (e_v) chk($sformatf("dut%0d tx_data", d), o_d, m_msg[d][5 - m_left[d]]);
        chk($sformatf("dut%0d busy", d), {7'b0, o_b}, {7'b0, e_b});
        chk($sformatf("dut%0d reject", d), {7'b0, o_r}, {7'b0, m_rej[d]});
        chk($sformatf("dut%0d position", d), o_p, 8'(m_pos[d]));
        chk($sformatf("dut%0d drop_count", d), o_c, 8'((m_drops[d] > 255) ? 255 : m_drops[d]));
    endtask

    task automatic cycle(input logic r, input logic b, input logic s,
                         input logic [7:0] p, input logic rdy);
        reset = r; buy_order = b; sell_order = s; price = p; tx_ready = rdy;
        @(posedge clk);
        for (int d = 0; d < NDUT; d++) model_step(d);
        #1;
        for (int d = 0; d < NDUT; d++) check_dut(d);
    endtask

    initial begin
        logic b, s;
        reset = 1'b1; buy_order = 1'b0; sell_order = 1'b0; price = 8'h00; tx_ready = 1'b1;

        cycle(1, 0, 0, 8'h00, 1);
        cycle(1, 0, 0, 8'h00, 1);
        chk("reset tx_data0", tx_data0, 8'h00);
        chk("reset tx_data1", tx_data1, 8'h00);

        // Buy at 0x70 with a ready sink; level held long past the message
        repeat (30) cycle(0, 1, 0, 8'h70, 1);
        repeat (5)  cycle(0, 0, 0, 8'h70, 1);

        // Sell at 0x90 with tx_ready toggling each cycle
        for (int i = 0; i < 40; i++) cycle(0, 0, 1, 8'h90, (i % 2) == 0);
        repeat (3) cycle(0, 0, 0, 8'h90, 1);

        // Buy and sell rising together
        repeat (5) cycle(0, 1, 1, 8'h33, 1);
        repeat (5) cycle(0, 0, 0, 8'h33, 1);

        // Buy held for 100 cycles
        repeat (100) cycle(0, 1, 0, 8'h55, 1);
        repeat (3)   cycle(0, 0, 0, 8'h55, 1);

        // New edges during SEND (sink stalled) and during COOL
        cycle(0, 1, 0, 8'h21, 0);
        cycle(0, 1, 0, 8'h21, 0);
        cycle(0, 0, 0, 8'h21, 0);
        cycle(0, 1, 0, 8'h21, 0);
        repeat (8) cycle(0, 1, 0, 8'h21, 1);
        cycle(0, 0, 0, 8'h21, 1);
        cycle(0, 1, 0, 8'h21, 1);
        repeat (30) cycle(0, 0, 0, 8'h21, 1);

        // Sell brings position down, then reset after byte 2 is accepted
        cycle(0, 0, 1, 8'h44, 1);
        cycle(0, 0, 1, 8'h44, 1);
        cycle(0, 0, 1, 8'h44, 1);
        cycle(0, 0, 1, 8'h44, 1);
        cycle(1, 0, 1, 8'h44, 1);
        cycle(0, 0, 0, 8'h44, 1);
        cycle(0, 1, 0, 8'h66, 1);
        repeat (30) cycle(0, 0, 0, 8'h66, 1);

        // Frequent buy edges: drives position to the limit and saturates drop_count
        for (int i = 0; i < 1300; i++) cycle(0, (i % 4) < 2, 0, 8'(i), 1);

        // Randomized traffic
        b = 0; s = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 7) == 0) b = ~b;
            if ($urandom_range(0, 7) == 0) s = ~s;
            cycle($urandom_range(0, 599) == 0, b, s, 8'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
